// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_WDOG_EN to add a watchdog that aborts stuck frames and raises a sticky err.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                   clk_uart,
  input  logic                   clrn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             tx_d_in,
  output logic                   tx_send,
  input  logic                   tx_sending,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  input  logic                   err_clr,
  output logic                   err
);

  localparam int IW = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    last_reg, last_next;
  logic [NUM_REQ-1:0] ack_next;
  logic [7:0]         d_next;
  logic               send_next;
  logic [ID_W-1:0]    gid_next;

  logic [7:0]         src_byte [NUM_REQ];
  logic [NUM_REQ-1:0] hit;
  logic [IW-1:0]      shamt;
  logic [IW-1:0]      win_idx;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic               trip;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
      assign src_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Rotate requests so bit k is the source k+1 places after the last winner.
  assign shamt = {1'b0, last_reg} + IW'(1);
  assign hit   = NUM_REQ'({req, req} >> shamt);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        win_found = 1'b1;
        win_idx   = shamt + IW'(k);
      end
    end
    if (win_idx >= IW'(NUM_REQ)) begin
      win_idx = win_idx - IW'(NUM_REQ);
    end
    win_id = win_idx[ID_W-1:0];
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    ack_next   = '0;
    send_next  = 1'b0;
    d_next     = tx_d_in;
    gid_next   = grant_id;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = WAIT_START;
          last_next  = win_id;
          gid_next   = win_id;
          d_next     = src_byte[win_id];
          ack_next   = NUM_REQ'(1) << win_id;
          send_next  = 1'b1;
        end
      end
      WAIT_START: begin
        if (tx_sending) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_sending) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (trip) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_uart or negedge clrn) begin
    if (!clrn) begin
      state_reg <= IDLE;
      last_reg  <= ID_W'(NUM_REQ - 1);
      ack       <= '0;
      tx_send   <= 1'b0;
      tx_d_in   <= 8'h00;
      grant_id  <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      ack       <= ack_next;
      tx_send   <= send_next;
      tx_d_in   <= d_next;
      grant_id  <= gid_next;
    end
  end

  assign busy = (state_reg != IDLE);

`ifdef UART_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;

  logic [WDOG_W-1:0] wdog_reg, wdog_next;
  logic              err_reg, err_next;

  assign trip = (state_reg != IDLE) && (wdog_reg == WDOG_W'(WDOG_CYCLES - 1));

  // Counter restarts on every state change; a trip beats a same-cycle err_clr.
  always_comb begin
    wdog_next = '0;
    if ((state_next == state_reg) && (state_reg != IDLE)) begin
      wdog_next = wdog_reg + WDOG_W'(1);
    end
    err_next = err_reg;
    if (trip) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk_uart or negedge clrn) begin
    if (!clrn) begin
      wdog_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      wdog_reg <= wdog_next;
      err_reg  <= err_next;
    end
  end

  assign err = err_reg;
`else
  logic unused_cfg;

  assign trip       = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = err_clr ^ (WDOG_CYCLES == 0);
`endif

endmodule
